// File: rtl/bus_source_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_source_encoder_if
//  Purpose  : Request/select bundle between bus control and the source encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface bus_source_encoder_if #(
  parameter int NUM_SRC = 27,
  parameter int CNT_W   = 8
);
  logic [NUM_SRC-1:0] out_req;
  logic               hold;
  logic [4:0]         select_signal;
  logic [NUM_SRC-1:0] grant;
  logic               grant_valid;
  logic               conflict;
  logic [CNT_W-1:0]   conflict_count;

  modport master (
    output out_req, hold,
    input  select_signal, grant, grant_valid, conflict, conflict_count
  );

  modport slave (
    input  out_req, hold,
    output select_signal, grant, grant_valid, conflict, conflict_count
  );
endinterface
`default_nettype wire

// File: rtl/bus_source_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : bus_source_encoder
//  Purpose  : Registers a 5-bit bus-mux select from per-source drive requests,
//             arbitrating and counting multi-driver conflicts.
//  Revision : 1.0  initial release
// ============================================================================
module bus_source_encoder #(
  parameter int NUM_SRC = 27,
  parameter int CNT_W   = 8,
  parameter bit STRICT  = 1'b0
) (
  input  wire logic            clock,
  input  wire logic            reset,
  bus_source_encoder_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    CONFLICT = 2'd2
  } state_t;

  localparam logic [NUM_SRC-1:0] C_REQ_ONE = NUM_SRC'(1);
  localparam logic [CNT_W-1:0]   C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_MAX = '1;

  state_t             r_state;
  logic [4:0]         r_select;
  logic [NUM_SRC-1:0] r_grant;
  logic               r_grantValid;
  logic               r_conflict;
  logic [CNT_W-1:0]   r_conflictCount;

  logic               w_anyReq;
  logic               w_multiReq;
  logic [4:0]         w_lowIdx;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_anyReq   = |bus.out_req;
  assign w_multiReq = |(bus.out_req & (bus.out_req - C_REQ_ONE));

  always_comb begin
    w_lowIdx = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.out_req[i]) w_lowIdx = 5'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= IDLE;
      r_select        <= 5'd0;
      r_grant         <= '0;
      r_grantValid    <= 1'b0;
      r_conflict      <= 1'b0;
      r_conflictCount <= '0;
    end else if (r_state == DRIVE && bus.hold) begin
      // Held transfer: grant frozen and requests deliberately not inspected.
      r_conflict <= 1'b0;
    end else if (!w_anyReq) begin
      r_state      <= IDLE;
      r_select     <= 5'd0;
      r_grant      <= '0;
      r_grantValid <= 1'b0;
      r_conflict   <= 1'b0;
    end else if (!w_multiReq) begin
      r_state      <= DRIVE;
      r_select     <= w_lowIdx + 5'd1;
      r_grant      <= C_REQ_ONE << w_lowIdx;
      r_grantValid <= 1'b1;
      r_conflict   <= 1'b0;
    end else begin
      r_state    <= CONFLICT;
      r_conflict <= 1'b1;
      if (r_conflictCount != C_CNT_MAX) r_conflictCount <= r_conflictCount + C_CNT_ONE;
      if (STRICT) begin
        r_select     <= 5'd0;
        r_grant      <= '0;
        r_grantValid <= 1'b0;
      end else begin
        r_select     <= w_lowIdx + 5'd1;
        r_grant      <= C_REQ_ONE << w_lowIdx;
        r_grantValid <= 1'b1;
      end
    end
  end

  assign bus.select_signal  = r_select;
  assign bus.grant          = r_grant;
  assign bus.grant_valid    = r_grantValid;
  assign bus.conflict       = r_conflict;
  assign bus.conflict_count = r_conflictCount;
endmodule
`default_nettype wire

// File: tb/tb_bus_source_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_source_encoder
//  Purpose  : Directed bench driving three encoder configurations in lockstep
//             (default, STRICT=1, CNT_W=2) against a rule-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_source_encoder;
  localparam int N = 27;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         hold;

  int passCount = 0;
  int totalCount = 0;

  always #5 clock = ~clock;

  bus_source_encoder_if #(.NUM_SRC(N), .CNT_W(8)) busA ();
  bus_source_encoder_if #(.NUM_SRC(N), .CNT_W(8)) busB ();
  bus_source_encoder_if #(.NUM_SRC(N), .CNT_W(2)) busC ();

  assign busA.out_req = req;  assign busA.hold = hold;
  assign busB.out_req = req;  assign busB.hold = hold;
  assign busC.out_req = req;  assign busC.hold = hold;

  bus_source_encoder #(.NUM_SRC(N), .CNT_W(8), .STRICT(1'b0)) dutA (.clock(clock), .reset(reset), .bus(busA));
  bus_source_encoder #(.NUM_SRC(N), .CNT_W(8), .STRICT(1'b1)) dutB (.clock(clock), .reset(reset), .bus(busB));
  bus_source_encoder #(.NUM_SRC(N), .CNT_W(2), .STRICT(1'b0)) dutC (.clock(clock), .reset(reset), .bus(busC));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: what each configuration must show, from the request rules alone.
  int  mSel [3];
  int  mCnt [3];
  bit  mConf[3];
  bit  mDriving;
  bit  mValid = 1'b0;

  always @(posedge clock) begin
    int n, low;
    n = $countones(req);
    low = 0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) low = i;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        mSel[k] = 0; mCnt[k] = 0; mConf[k] = 0;
      end else if (mDriving && hold) begin
        mConf[k] = 0;
      end else if (n == 0) begin
        mSel[k] = 0; mConf[k] = 0;
      end else if (n == 1) begin
        mSel[k] = low + 1; mConf[k] = 0;
      end else begin
        mConf[k] = 1;
        mSel[k]  = (k == 1) ? 0 : low + 1;
        if (mCnt[k] < ((k == 2) ? 3 : 255)) mCnt[k] = mCnt[k] + 1;
      end
    end
    if (reset) mDriving = 0;
    else if (!(mDriving && hold)) mDriving = (n == 1);
    if (reset) mValid = 1'b1;
  end

  function automatic logic [31:0] expGrant(input int sel);
    return (sel == 0) ? 32'd0 : (32'd1 << (sel - 1));
  endfunction

  always @(negedge clock) begin
    if (mValid) begin
      chk("A.select", 32'(busA.select_signal), 32'(mSel[0]));
      chk("A.grant",  32'(busA.grant), expGrant(mSel[0]));
      chk("A.valid",  32'(busA.grant_valid), 32'(mSel[0] != 0));
      chk("A.conf",   32'(busA.conflict), 32'(mConf[0]));
      chk("A.count",  32'(busA.conflict_count), 32'(mCnt[0]));
      chk("B.select", 32'(busB.select_signal), 32'(mSel[1]));
      chk("B.grant",  32'(busB.grant), expGrant(mSel[1]));
      chk("B.valid",  32'(busB.grant_valid), 32'(mSel[1] != 0));
      chk("B.conf",   32'(busB.conflict), 32'(mConf[1]));
      chk("B.count",  32'(busB.conflict_count), 32'(mCnt[1]));
      chk("C.select", 32'(busC.select_signal), 32'(mSel[2]));
      chk("C.grant",  32'(busC.grant), expGrant(mSel[2]));
      chk("C.valid",  32'(busC.grant_valid), 32'(mSel[2] != 0));
      chk("C.conf",   32'(busC.conflict), 32'(mConf[2]));
      chk("C.count",  32'(busC.conflict_count), 32'(mCnt[2]));
    end
  end

  // Apply inputs, let one rising edge act on them, settle at the falling edge.
  task automatic step(input logic r, input logic [N-1:0] q, input logic h);
    reset = r; req = q; hold = h;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; req = N'(1); hold = 1'b0;
    @(negedge clock);

    // Reset holds everything at zero even with a request present.
    step(1'b1, N'(1), 1'b0);
    step(1'b1, N'(1), 1'b0);
    chk("lit.rst.select", 32'(busA.select_signal), 32'd0);
    chk("lit.rst.grant",  32'(busA.grant), 32'd0);
    chk("lit.rst.count",  32'(busA.conflict_count), 32'd0);
    step(1'b0, N'(1), 1'b0);
    chk("lit.r0.select", 32'(busA.select_signal), 32'd1);

    // PC drives.
    step(1'b0, N'(1) << 20, 1'b0);
    chk("lit.pc.select", 32'(busA.select_signal), 32'd21);
    chk("lit.pc.grant",  32'(busA.grant), 32'h0010_0000);
    chk("lit.pc.valid",  32'(busA.grant_valid), 32'd1);

    // Held R5 transfer ignores a move to MAR until hold drops.
    step(1'b0, N'(1) << 5, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, N'(1) << 26, 1'b1);
      chk("lit.hold.select", 32'(busA.select_signal), 32'd6);
    end
    step(1'b0, N'(1) << 26, 1'b1 ^ 1'b1);
    chk("lit.mar.select", 32'(busA.select_signal), 32'd27);

    // R3 + MDR conflict; hold is meaningless while conflicted.
    step(1'b0, (N'(1) << 3) | (N'(1) << 21), 1'b0);
    chk("lit.conf.A.select", 32'(busA.select_signal), 32'd4);
    chk("lit.conf.A.pulse",  32'(busA.conflict), 32'd1);
    chk("lit.conf.A.count",  32'(busA.conflict_count), 32'd1);
    chk("lit.conf.B.select", 32'(busB.select_signal), 32'd0);
    chk("lit.conf.B.valid",  32'(busB.grant_valid), 32'd0);
    chk("lit.conf.B.count",  32'(busB.conflict_count), 32'd1);
    step(1'b0, N'(1) << 9, 1'b1);
    chk("lit.confhold.select", 32'(busA.select_signal), 32'd10);
    chk("lit.confhold.pulse",  32'(busA.conflict), 32'd0);
    step(1'b0, '0, 1'b0);
    step(1'b0, N'(1) << 2, 1'b1);
    chk("lit.idlehold.select", 32'(busA.select_signal), 32'd3);

    // Saturation on the 2-bit counter across five back-to-back conflicts.
    step(1'b1, '0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, (N'(1) << (c + 1)) | (N'(1) << 26), 1'b0);
      chk("lit.sat.C.count", 32'(busC.conflict_count), (c < 3) ? 32'(c + 1) : 32'd3);
      chk("lit.sat.C.pulse", 32'(busC.conflict), 32'd1);
    end
    chk("lit.sat.A.count", 32'(busA.conflict_count), 32'd5);

    // Reset during a held transfer drops the grant at once.
    step(1'b0, N'(1) << 7, 1'b0);
    step(1'b1, N'(1) << 7, 1'b1);
    chk("lit.rsthold.select", 32'(busA.select_signal), 32'd0);
    chk("lit.rsthold.grant",  32'(busA.grant), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("lit.after.select", 32'(busA.select_signal), 32'd0);

    // Top source, and a full-request conflict.
    step(1'b0, N'(1) << 26, 1'b0);
    step(1'b0, '1, 1'b0);
    chk("lit.all.select", 32'(busA.select_signal), 32'd1);
    step(1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
`default_nettype wire
